// File: rtl/mem_pkg.sv
// Shared types and constants for the MIPS memory stage.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam logic MEM_WORD = 1'b0;
    localparam logic MEM_BYTE = 1'b1;

    localparam logic [3:0] BE_NONE  = 4'h0;
    localparam logic [3:0] BE_WORD  = 4'hF;
    localparam logic [3:0] BE_LANE0 = 4'h1;

endpackage

// File: rtl/mem_align.sv
// Store lane replication, byte enables, and load lane select with sign extension.
module mem_align
    import mem_pkg::*;
(
    input  logic        mem_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data_t,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data
);

    logic [7:0] lane;

    always_comb begin
        wdata     = data_t;
        be        = BE_WORD;
        load_data = rdata;
        lane      = 8'h00;
        if (mem_type == MEM_BYTE) begin
            wdata = {4{data_t[7:0]}};
            be    = BE_LANE0 << addr_lo;
            case (addr_lo)
                2'd0:    lane = rdata[7:0];
                2'd1:    lane = rdata[15:8];
                2'd2:    lane = rdata[23:16];
                default: lane = rdata[31:24];
            endcase
            load_data = {{24{lane[7]}}, lane};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: data-bus access FSM with timeout, redirect, forwarding probe
// and the MEM/WB pipeline register.
module mem_stage
    import mem_pkg::*;
#(
    parameter int BUS_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        is_branch,
    input  logic        alu_zero,
    input  logic        is_jump,
    input  logic [31:0] pc_branch,
    input  logic [31:0] pc_jump,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_type,
    input  logic        mem_to_reg,
    input  logic        reg_write,
    input  logic [31:0] alu_out,
    input  logic [31:0] data_t,
    input  logic [4:0]  reg_addr,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic        mem_busy,
    output logic        dmem_req,
    output logic        dmem_wr,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  reg_probe,
    output logic [31:0] data_probe,
    output logic        write_probe,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg,
    output logic        wb_write,
    output logic        mem_error
);

    localparam int CW = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(BUS_TIMEOUT - 1);

    mem_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic        wb_write_q, wb_write_d;

    logic        memop, misaligned;
    logic [31:0] st_wdata, load_data, result;
    logic [3:0]  st_be;

    mem_align u_align (
        .mem_type  (mem_type),
        .addr_lo   (alu_out[1:0]),
        .data_t    (data_t),
        .rdata     (rdata_q),
        .wdata     (st_wdata),
        .be        (st_be),
        .load_data (load_data)
    );

    assign memop      = mem_read | mem_write;
    assign misaligned = (mem_type == MEM_WORD) && (alu_out[1:0] != 2'b00);
    assign mem_busy   = ((state_q == ST_IDLE) && memop) || (state_q == ST_REQ);
    assign result     = mem_to_reg ? load_data : alu_out;

    assign pc_src    = is_jump | (is_branch & alu_zero);
    assign pc_target = is_jump ? pc_jump : pc_branch;

    // Load results only become forwardable once the bus data is captured.
    assign reg_probe   = reg_addr;
    assign data_probe  = result;
    assign write_probe = reg_write & (~mem_to_reg | (state_q == ST_DONE));

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        err_d      = err_q;
        rdata_d    = rdata_q;
        req_d      = req_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wb_data_d  = wb_data_q;
        wb_reg_d   = wb_reg_q;
        wb_write_d = wb_write_q;

        case (state_q)
            ST_IDLE: begin
                if (memop) begin
                    if (misaligned) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        wr_d    = mem_write;
                        addr_d  = {alu_out[31:2], 2'b00};
                        wdata_d = st_wdata;
                        be_d    = st_be;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    rdata_d = dmem_rdata;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (we) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (we && !mem_busy) begin
            wb_data_d  = result;
            wb_reg_d   = reg_addr;
            wb_write_d = reg_write;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            req_q      <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= BE_NONE;
            wb_data_q  <= '0;
            wb_reg_q   <= '0;
            wb_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            req_q      <= req_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wb_data_q  <= wb_data_d;
            wb_reg_q   <= wb_reg_d;
            wb_write_q <= wb_write_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_wr    = wr_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign wb_data    = wb_data_q;
    assign wb_reg     = wb_reg_q;
    assign wb_write   = wb_write_q;
    assign mem_error  = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage against a transaction-level model.
module tb_mem_stage;

    localparam int TO = 64;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, we, is_branch, alu_zero, is_jump;
    logic        mem_read, mem_write, mem_type, mem_to_reg, reg_write, dmem_ack;
    logic [31:0] pc_branch, pc_jump, alu_out, data_t, dmem_rdata;
    logic [4:0]  reg_addr;
    logic        pc_src, mem_busy, dmem_req, dmem_wr, write_probe, wb_write, mem_error;
    logic [31:0] pc_target, dmem_addr, dmem_wdata, data_probe, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  reg_probe, wb_reg;

    mem_stage #(.BUS_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .we(we),
        .is_branch(is_branch), .alu_zero(alu_zero), .is_jump(is_jump),
        .pc_branch(pc_branch), .pc_jump(pc_jump),
        .mem_read(mem_read), .mem_write(mem_write), .mem_type(mem_type),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_out(alu_out), .data_t(data_t), .reg_addr(reg_addr),
        .pc_src(pc_src), .pc_target(pc_target), .mem_busy(mem_busy),
        .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .reg_probe(reg_probe), .data_probe(data_probe), .write_probe(write_probe),
        .wb_data(wb_data), .wb_reg(wb_reg), .wb_write(wb_write), .mem_error(mem_error)
    );

    int total = 0;
    int bad   = 0;

    // Model state carried across transactions
    logic        err_m = 1'b0;
    logic [31:0] prev_wbd = '0;
    logic [4:0]  prev_wbr = '0;
    logic        prev_wbw = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input logic typ);
        int b;
        if (!typ) return rd;
        b = int'((rd >> (8 * int'(a[1:0]))) & 32'hFF);
        if (b >= 128) b = b - 256;
        return 32'(b);
    endfunction

    // Runs the instruction currently on the EX inputs; called just after a rising edge.
    // ack_dly: REQ cycle (0-based) in which the slave acks; negative = never.
    task automatic run_op(input int ack_dly, input int hold, input bit spur);
        bit          memop, aligned, e;
        int          exp_busy, exp_req, busy_n, req_n, cyc;
        bit          bus_seen;
        logic [31:0] ld, res, exp_wd;
        logic [3:0]  exp_be;
        logic        exp_wp;
        memop   = mem_read | mem_write;
        aligned = mem_type || (alu_out[1:0] == 2'b00);
        if (!memop)                          begin exp_busy = 0;      exp_req = 0;         e = 0; end
        else if (!aligned)                   begin exp_busy = 1;      exp_req = 0;         e = 1; end
        else if (ack_dly < 0 || ack_dly >= TO) begin exp_busy = TO + 1; exp_req = TO;      e = 1; end
        else                                 begin exp_busy = ack_dly + 2; exp_req = ack_dly + 1; e = 0; end
        ld     = e ? 32'h0 : model_load(dmem_rdata, alu_out, mem_type);
        res    = mem_to_reg ? ld : alu_out;
        exp_wp = reg_write && (!mem_to_reg || memop);
        exp_be = mem_type ? (4'h1 << alu_out[1:0]) : 4'hF;
        exp_wd = mem_type ? (32'(data_t[7:0]) * 32'h0101_0101) : data_t;
        busy_n = 0; req_n = 0; cyc = 0; bus_seen = 0;
        we = 1'b1;

        @(negedge clk);
        check("pc_src", pc_src, is_jump || (is_branch && alu_zero));
        check("pc_target", pc_target, is_jump ? pc_jump : pc_branch);
        check("reg_probe", reg_probe, reg_addr);
        while (mem_busy === 1'b1 && cyc < 200) begin
            busy_n++;
            if (dmem_req === 1'b1) begin
                req_n++;
                if (!bus_seen) begin
                    bus_seen = 1;
                    check("dmem_addr", dmem_addr, alu_out & 32'hFFFF_FFFC);
                    check("dmem_be", dmem_be, exp_be);
                    check("dmem_wdata", dmem_wdata, exp_wd);
                    check("dmem_wr", dmem_wr, mem_write);
                end
                dmem_ack = (req_n - 1 == ack_dly);
            end else begin
                dmem_ack = spur;
            end
            @(negedge clk);
            cyc++;
        end
        dmem_ack = 1'b0;
        check("busy_bound", mem_busy, 1'b0);
        check("busy_cycles", busy_n, exp_busy);
        check("req_cycles", req_n, exp_req);
        check("req_low_done", dmem_req, 1'b0);
        check("write_probe", write_probe, exp_wp);
        check("data_probe", data_probe, res);

        if (hold > 0) begin
            we = 1'b0;
            repeat (hold) @(negedge clk);
            check("hold_busy", mem_busy, 1'b0);
            check("hold_probe", data_probe, res);
            check("hold_wb_data", wb_data, prev_wbd);
            check("hold_wb_reg", wb_reg, prev_wbr);
            we = 1'b1;
        end

        @(posedge clk);
        #1;
        err_m    = err_m | e;
        prev_wbd = res;
        prev_wbr = reg_addr;
        prev_wbw = reg_write;
        check("wb_data", wb_data, prev_wbd);
        check("wb_reg", wb_reg, prev_wbr);
        check("wb_write", wb_write, prev_wbw);
        check("mem_error", mem_error, err_m);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic set_op(input bit rd, input bit wr, input bit typ, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] ra, input bit rw);
        mem_read = rd; mem_write = wr; mem_type = typ; alu_out = a; data_t = d;
        reg_addr = ra; reg_write = rw; mem_to_reg = rd;
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        is_branch = 1'b0; alu_zero = 1'b0; is_jump = 1'b0; pc_branch = '0; pc_jump = '0;
        set_op(0, 0, 0, 32'h0, 32'h0, 5'd0, 0);
        #12;
        check("rst_dmem_req", dmem_req, 1'b0);
        check("rst_dmem_be", dmem_be, 4'h0);
        check("rst_dmem_addr", dmem_addr, 32'h0);
        check("rst_dmem_wdata", dmem_wdata, 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_wb_write", wb_write, 1'b0);
        check("rst_mem_error", mem_error, 1'b0);
        check("rst_mem_busy", mem_busy, 1'b0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Word load, ack in first REQ cycle
        dmem_rdata = 32'hDEAD_BEEF;
        set_op(1, 0, 0, 32'h100, 32'h0, 5'd8, 1);
        run_op(0, 0, 0);
        check("wl_wb_data", wb_data, 32'hDEAD_BEEF);

        // Byte store to lane 3
        set_op(0, 1, 1, 32'h203, 32'h1234_5678, 5'd0, 0);
        run_op(1, 1, 1);

        // Byte load of lane 1 with sign bit set
        dmem_rdata = 32'h0000_8000;
        set_op(1, 0, 1, 32'h201, 32'h0, 5'd9, 1);
        run_op(2, 0, 0);
        check("bl_wb_data", wb_data, 32'hFFFF_FF80);

        // Redirect: jump wins over taken branch
        is_branch = 1; alu_zero = 1; is_jump = 1; pc_jump = 32'h400; pc_branch = 32'h800;
        set_op(0, 0, 0, 32'h55, 32'h0, 5'd3, 1);
        #1;
        check("redir_src", pc_src, 1'b1);
        check("redir_target", pc_target, 32'h400);
        run_op(0, 2, 0);

        // Randomized aligned traffic
        for (int i = 0; i < 24; i++) begin
            int kind;
            logic [31:0] a;
            bit typ;
            kind = $urandom_range(0, 2);
            typ  = 1'($urandom_range(0, 1));
            a    = $urandom;
            if (!typ) a[1:0] = 2'b00;
            is_branch = 1'($urandom); alu_zero = 1'($urandom); is_jump = 1'($urandom);
            pc_branch = $urandom; pc_jump = $urandom;
            dmem_rdata = $urandom;
            set_op(kind == 1, kind == 2, typ, a, $urandom, 5'($urandom), 1'($urandom));
            run_op($urandom_range(0, 5), $urandom_range(0, 2), 1'($urandom));
        end

        // Misaligned word load: no bus cycle, sticky error, zero data
        set_op(1, 0, 0, 32'h102, 32'h0, 5'd4, 1);
        run_op(0, 0, 1);
        check("mis_wb_data", wb_data, 32'h0);

        // Slave never acks
        dmem_rdata = 32'hFFFF_FFFF;
        set_op(1, 0, 0, 32'h340, 32'h0, 5'd5, 1);
        run_op(-1, 0, 0);

        // Reset asserted mid-REQ drops the request without a clock edge
        set_op(1, 0, 0, 32'h300, 32'h0, 5'd6, 1);
        we = 1'b1;
        repeat (3) @(negedge clk);
        check("midreq_req_high", dmem_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("midreq_req_drop", dmem_req, 1'b0);
        check("midreq_err_clr", mem_error, 1'b0);
        check("midreq_wb_write", wb_write, 1'b0);
        mem_read = 1'b0;
        @(negedge clk); reset = 1'b1;
        err_m = 1'b0; prev_wbd = '0; prev_wbr = '0; prev_wbw = 1'b0;
        @(posedge clk); #1;

        // Word store after recovery
        set_op(0, 1, 0, 32'h404, 32'hA5A5_0F0F, 5'd0, 0);
        run_op(2, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline memory stage of the MIPS core. It sits between the EX/MEM and MEM/WB pipeline registers and receives everything the execute stage registers out. It drives loads and stores onto a request/acknowledge data-memory bus and stalls the pipeline while an access is outstanding. It also resolves branch/jump redirection and publishes a forwarding probe for the hazard logic.

## Interface
Parameters:
- BUS_TIMEOUT, 64, cycles `dmem_req` may stay unacknowledged before the access is abandoned with `mem_error`.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- we  in  1  pipeline advance enable from the hazard unit.
- is_branch, alu_zero, is_jump  in  1 each  control from EX.
- pc_branch, pc_jump  in  32 each  redirect targets from EX.
- mem_read, mem_write  in  1 each  load / store request.
- mem_type  in  1  0 = word, 1 = byte.
- mem_to_reg, reg_write  in  1 each  writeback control.
- alu_out  in  32  address for memory ops; result otherwise.
- data_t  in  32  store data.
- reg_addr  in  5  destination register.
- pc_src  out  1  redirect fetch.
- pc_target  out  32  redirect address.
- mem_busy  out  1  stall request to the hazard unit.
- dmem_req, dmem_wr  out  1 each  bus request / write flag.
- dmem_addr  out  32  word-aligned bus address.
- dmem_wdata  out  32  bus write data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  bus completion.
- dmem_rdata  in  32  bus read data.
- reg_probe, data_probe, write_probe  out  5 / 32 / 1  forwarding probe.
- wb_data  out  32  MEM/WB result.
- wb_reg  out  5  MEM/WB destination register.
- wb_write  out  1  MEM/WB write enable.
- mem_error  out  1  sticky error; cleared only by reset.

## Operation
- `memop = mem_read | mem_write`.
- FSM states: IDLE, REQ, DONE.
  - IDLE → REQ when `memop` is set and the address is aligned.
  - IDLE → DONE when `memop` is set and the access is a misaligned word (`alu_out[1:0] != 0`, `mem_type = 0`). This sets `mem_error` and issues no bus cycle; loaded data is 0.
  - REQ → DONE on `dmem_ack`; `dmem_rdata` is captured on that edge.
  - REQ → DONE when the timeout counter reaches BUS_TIMEOUT-1. This sets `mem_error`; loaded data is 0.
  - DONE → IDLE on `we`.
- `mem_busy = (IDLE & memop) | REQ`. DONE is not busy.
- Bus outputs are registered.
  - `dmem_req` is high for exactly the cycles spent in REQ.
  - `dmem_wr = mem_write`.
  - `dmem_addr = {alu_out[31:2], 2'b00}`.
- Word access: `dmem_be = 4'hF`, `dmem_wdata = data_t`.
- Byte access: `dmem_be = 1 << alu_out[1:0]`, `dmem_wdata = {4{data_t[7:0]}}`. Load data is the selected lane, sign-extended to 32 bits.
- Redirect (combinational):
  - `pc_src = is_jump | (is_branch & alu_zero)`.
  - `pc_target = is_jump ? pc_jump : pc_branch`; jump has priority.
- MEM/WB registers load on `we & ~mem_busy`:
  - `wb_data = mem_to_reg ? load_data : alu_out`.
  - `wb_reg = reg_addr`, `wb_write = reg_write`.
- Probe (combinational):
  - `reg_probe = reg_addr`.
  - `data_probe = mem_to_reg ? load_data : alu_out`.
  - `write_probe = reg_write & (~mem_to_reg | DONE)`, i.e. load data is forwardable only once captured.

## Timing
- Reset (asynchronous, low):
  - State IDLE, timeout counter 0.
  - `dmem_req`, `dmem_wr`, `dmem_addr`, `dmem_wdata`, `dmem_be` = 0.
  - `wb_data`, `wb_reg`, `wb_write`, `mem_error` = 0.
- A reset during REQ drops `dmem_req` immediately. The slave must tolerate an abandoned request.
- Non-memory instruction: zero stall; MEM/WB is updated one edge after EX presents it with `we`.
- Memory access, ack in the first REQ cycle:
  - Cycle 0: IDLE, busy.
  - Cycle 1: REQ, busy, ack.
  - Cycle 2: DONE, not busy; MEM/WB loads at the end of cycle 2 if `we`.
  - Minimum stall is 2 cycles.
- Each extra cycle of `dmem_ack` delay adds one stall cycle.
- `dmem_ack` outside REQ is ignored.
- `we` low in DONE holds DONE and the captured data indefinitely.
- EX inputs are guaranteed stable while `mem_busy` or DONE, because the pipeline is stalled.

## Structure
- Package `mem_pkg`:
  - FSM state encoding.
  - `MEM_WORD` / `MEM_BYTE` constants.
  - Byte-enable lane constants.
- Sub-module `mem_align`: combinational store lane replication, byte-enable generation, and load lane select plus sign extension.
- The FSM, timeout counter and pipeline registers live in `mem_stage`.

## Test plan
- Word load at `alu_out = 0x100`, `mem_to_reg = 1`, `reg_addr = 8`, slave acks in the first REQ cycle with `0xDEADBEEF`:
  - `dmem_be = F`, `mem_busy` high 2 cycles.
  - `write_probe` rises in DONE with `data_probe = 0xDEADBEEF`.
  - Then `wb_data = 0xDEADBEEF`, `wb_reg = 8`.
- Byte store of `data_t = 0x12345678` at `0x203`: `dmem_addr = 0x200`, `dmem_be = 4'b1000`, `dmem_wdata = 0x78787878`.
- Byte load at `0x201`, `rdata = 0x0000_8000`: `wb_data = 0xFFFFFF80`.
- Misaligned word load at `0x102`: no `dmem_req`, `mem_error = 1`, `wb_data = 0`.
- Slave never acks with BUS_TIMEOUT = 64: `dmem_req` high exactly 64 cycles, then DONE with `mem_error = 1`.
- Redirect:
  - `is_branch = 1`, `alu_zero = 1`, `is_jump = 1`, `pc_jump = 0x400`, `pc_branch = 0x800`: `pc_src = 1`, `pc_target = 0x400`.
  - Assert reset mid-REQ: `dmem_req` drops without waiting for a clock edge.
